// File: rtl/alu_arbiter_if.sv
// Bus between the two requesters, the shared ALU and the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [2:0]       op0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [2:0]       op1;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_c;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic             err;

    modport slave (
        input  req0, a0, b0, op0, req1, a1, b1, op1, alu_c,
        output gnt0, gnt1, alu_a, alu_b, alu_op, done0, done1, result, err
    );

    modport master (
        output req0, a0, b0, op0, req1, a1, b1, op1, alu_c,
        input  gnt0, gnt1, alu_a, alu_b, alu_op, done0, done1, result, err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lends one shared combinational ALU to two requesters,
// one operation every three cycles: sample/grant, execute, return result.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    alu_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t state;
    state_t nextState;
    logic   prio;
    logic   owner;
    logic   take;
    logic   winner;
    logic   badOp;

    assign badOp = (bus.alu_op == 3'b110) || (bus.alu_op == 3'b111);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Requests are only looked at in IDLE; a tie goes to the requester named by prio.
    always_comb begin
        nextState = state;
        take      = 1'b0;
        winner    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    take      = 1'b1;
                    winner    = (bus.req0 && bus.req1) ? prio : bus.req1;
                    nextState = EXEC;
                end
            end
            EXEC:    nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // ALU inputs are left holding their last issued values between operations.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.gnt0   <= 1'b0;
            bus.gnt1   <= 1'b0;
            bus.done0  <= 1'b0;
            bus.done1  <= 1'b0;
            bus.err    <= 1'b0;
            bus.result <= '0;
            bus.alu_a  <= '0;
            bus.alu_b  <= '0;
            bus.alu_op <= '0;
            owner      <= 1'b0;
            prio       <= 1'b0;
        end else begin
            bus.gnt0  <= 1'b0;
            bus.gnt1  <= 1'b0;
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            bus.err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        bus.alu_a  <= winner ? bus.a1 : bus.a0;
                        bus.alu_b  <= winner ? bus.b1 : bus.b0;
                        bus.alu_op <= winner ? bus.op1 : bus.op0;
                        owner      <= winner;
                        bus.gnt0   <= ~winner;
                        bus.gnt1   <= winner;
                    end
                end
                EXEC: begin
                    bus.result <= badOp ? '0 : bus.alu_c;
                    bus.err    <= badOp;
                    bus.done0  <= ~owner;
                    bus.done1  <= owner;
                end
                DONE: begin
                    prio <= ~owner;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
